// File: rtl/el2_div_pkg.sv
// Shared types for the EXU divider.
//   el2_div_pkt_t : divide request from decode
//     valid  - request present this cycle
//     unsign - 1 = unsigned operands, 0 = two's-complement operands
//     rem    - 1 = return remainder, 0 = return quotient
package el2_div_pkg;

    typedef struct packed {
        logic valid;
        logic unsign;
        logic rem;
    } el2_div_pkt_t;

endpackage

// File: rtl/el2_exu_div_seq.sv
// Iterative 32-bit radix-2 restoring divide sequencer.
//
// Ports:
//   clk       in   core clock
//   rst       in   asynchronous active-high reset
//   dp        in   divide request packet (valid, unsign, rem)
//   dividend  in   rs1 operand, sampled on accept
//   divisor   in   rs2 operand, sampled on accept
//   cancel    in   pipeline flush, kills any in-flight operation
//   div_busy  out  high while iterating or sign-fixing; decode must hold
//   finish    out  one-cycle result-valid strobe
//   out       out  result register, held until the next finish
//
// Parameter:
//   FAST_SPECIAL  1 = divide-by-zero and signed overflow go straight to DONE
//                 0 = they run the full iteration, FIX substitutes the result
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | no operation; accepts a new request
// CALC  | 32 shift/subtract iterations, count 31 down to 0
// FIX   | sign correction, result select, out written
// DONE  | finish strobe; accepts a back-to-back request
module el2_exu_div_seq
    import el2_div_pkg::*;
#(
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  el2_div_pkt_t dp,
    input  logic [31:0]  dividend,
    input  logic [31:0]  divisor,
    input  logic         cancel,
    output logic         div_busy,
    output logic         finish,
    output logic [31:0]  out
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]  state;
    logic [4:0]  count;
    logic [32:0] r_q;
    logic [31:0] q_q;
    logic [31:0] b_mag_q;
    logic        rem_q;
    logic        qs_q;
    logic        rs_q;
    logic        special_q;
    logic [31:0] special_res_q;

    logic        accept;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        div_zero;
    logic        sgn_ovf;
    logic        special_in;
    logic [31:0] special_val;
    logic [32:0] r_shift;
    logic [33:0] diff;
    logic        take;
    logic [31:0] q_fix;
    logic [31:0] r_fix;
    logic [31:0] fix_res;

    assign div_busy = (state == CALC) | (state == FIX);
    assign finish   = (state == DONE) & ~cancel;
    assign accept   = dp.valid & ~div_busy & ~cancel;

    // Magnitudes: negating 0x80000000 yields 0x80000000, which is the
    // correct unsigned magnitude, so no special handling is needed.
    assign a_neg = dividend[31] & ~dp.unsign;
    assign b_neg = divisor[31]  & ~dp.unsign;
    assign a_mag = a_neg ? (32'd0 - dividend) : dividend;
    assign b_mag = b_neg ? (32'd0 - divisor)  : divisor;

    assign div_zero   = (divisor == 32'd0);
    assign sgn_ovf    = ~dp.unsign & (dividend == 32'h8000_0000) & (divisor == 32'hFFFF_FFFF);
    assign special_in = div_zero | sgn_ovf;

    always_comb begin
        special_val = 32'd0;
        if (div_zero) begin
            special_val = dp.rem ? dividend : 32'hFFFF_FFFF;
        end else begin
            special_val = dp.rem ? 32'd0 : 32'h8000_0000;
        end
    end

    // One restoring step. The trial difference is one bit wider than the
    // shifted remainder so its top bit is an unambiguous borrow.
    assign r_shift = {r_q[31:0], q_q[31]};
    assign diff    = {1'b0, r_shift} - {2'b00, b_mag_q};
    assign take    = ~diff[33];

    assign q_fix   = qs_q ? (32'd0 - q_q)        : q_q;
    assign r_fix   = rs_q ? (32'd0 - r_q[31:0])  : r_q[31:0];
    assign fix_res = special_q ? special_res_q : (rem_q ? r_fix : q_fix);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            count         <= 5'd0;
            r_q           <= 33'd0;
            q_q           <= 32'd0;
            b_mag_q       <= 32'd0;
            rem_q         <= 1'b0;
            qs_q          <= 1'b0;
            rs_q          <= 1'b0;
            special_q     <= 1'b0;
            special_res_q <= 32'd0;
            out           <= 32'd0;
        end else if (cancel) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        count         <= 5'd31;
                        r_q           <= 33'd0;
                        q_q           <= a_mag;
                        b_mag_q       <= b_mag;
                        rem_q         <= dp.rem;
                        qs_q          <= (dividend[31] ^ divisor[31]) & ~dp.unsign;
                        rs_q          <= dividend[31] & ~dp.unsign;
                        special_q     <= special_in;
                        special_res_q <= special_val;
                        if (FAST_SPECIAL && special_in) begin
                            out   <= special_val;
                            state <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    r_q   <= take ? diff[32:0] : r_shift;
                    q_q   <= {q_q[30:0], take};
                    count <= count - 5'd1;
                    if (count == 5'd0) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    out   <= fix_res;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/el2_exu_div_seq.md
# el2_exu_div_seq

Iterative 32-bit divide sequencer for the EXU. It accepts a divide packet of type `el2_div_pkt_t` (`valid`, `unsign`, `rem`) plus two operands from decode. It runs a radix-2 restoring divide over 32 cycles, applies sign correction, and returns a single-cycle result strobe to the writeback path. It also generates the busy/stall indication toward decode and honours pipeline flushes.

## Interface
- `FAST_SPECIAL`, default 1: divide-by-zero and signed overflow complete without iterating (result strobe one cycle after accept). When 0, these cases take the full latency but produce the same results.

Ports:
- `clk`  in  1  core clock
- `rst`  in  1  asynchronous, active-high reset
- `dp`  in  `el2_div_pkt_t`  divide request: `valid`, `unsign`, `rem`
- `dividend`  in  32  rs1 operand, sampled on accept
- `divisor`  in  32  rs2 operand, sampled on accept
- `cancel`  in  1  flush; kills any in-flight operation
- `div_busy`  out  1  high in CALC/FIX; decode must not issue
- `finish`  out  1  one-cycle result-valid strobe
- `out`  out  32  result register; holds its value until the next finish

## Operation
- States: IDLE, CALC, FIX, DONE. `div_busy` = (state==CALC | state==FIX).
- Accept = `dp.valid & ~div_busy & ~cancel`. Accept is legal in IDLE and DONE, which allows back-to-back operations. A `dp.valid` while busy is ignored.
- On accept, the block latches `unsign` and `rem`, the magnitudes |a| and |b|, and the quotient sign qs = (a[31]^b[31]) & ~unsign and remainder sign rs = a[31] & ~unsign. In signed mode, |0x80000000| is 0x80000000 as an unsigned value. The 33-bit partial remainder clears and the count loads 31.
- Special cases are detected on accept:
  - Divisor zero: quotient = 0xFFFF_FFFF, remainder = dividend.
  - Signed overflow (a = 0x8000_0000, b = 0xFFFF_FFFF, `unsign`=0): quotient = 0x8000_0000, remainder = 0.
  - With `FAST_SPECIAL`=1, the block goes directly to DONE with the special result. Otherwise the iteration still runs, but FIX forces the special result.
- CALC, per cycle:
  - Shift {R, Q} left 1 and try R − |b|.
  - If the result is non-negative, keep it and set Q[0]=1; otherwise restore and set Q[0]=0.
  - Decrement count. When count==0, go to FIX.
- FIX, one cycle: negate Q if qs, negate R if rs, select R when `rem`=1 and Q otherwise, write `out`, then go to DONE.
- DONE: `finish` = (state==DONE) & ~`cancel`. Next state is CALC or DONE on a new accept, IDLE otherwise.
- `cancel` in any state forces IDLE on the next edge and prevents accept that cycle. A `cancel` during DONE suppresses `finish`, but `out` has already been written.
- Reset values: state IDLE, `out`=0, `finish`=0, `div_busy`=0, count=0, R/Q=0.

## Timing
- Accept at edge N (with `dp.valid` high in cycle N−1 relative to sampling):
  - CALC occupies cycles N+1..N+32.
  - FIX occupies N+33.
  - `finish` is high in cycle N+34.
  - `out` is valid from N+34 onward.
- Special case with `FAST_SPECIAL`=1: `finish` is high in cycle N+1.
- Back-to-back: an accept in the DONE cycle starts the next CALC with no idle gap. Throughput is one divide per 34 cycles.
- `cancel` and `dp.valid` together: `cancel` wins and there is no accept.
- `rst` asserted mid-operation: all state clears immediately (asynchronous). No `finish` is ever produced for the killed operation.

## Test plan
- Unsigned 100 / 7, `rem`=0 → `finish` at N+34, `out`=14. Repeat with `rem`=1 → `out`=2.
- Signed −7 (0xFFFF_FFF9) / 2 → quotient 0xFFFF_FFFD (−3). With `rem`=1 → 0xFFFF_FFFF (−1). `div_busy` is high for exactly 33 cycles.
- Divide by zero, dividend 0x1234:
  - `rem`=0 → 0xFFFF_FFFF.
  - `rem`=1 → 0x1234.
  - `finish` at N+1 when `FAST_SPECIAL`=1; at N+34 when 0.
- Signed 0x8000_0000 / 0xFFFF_FFFF → quotient 0x8000_0000, remainder 0. Unsigned, the same operands → quotient 0, remainder 0x8000_0000.
- `cancel` at CALC cycle 10 → IDLE next cycle, no `finish`, `out` unchanged. A new request the following cycle completes normally.
- Back-to-back 0xFFFF_FFFF/1 then 9/3 (unsigned), the second issued in the DONE cycle → `finish` pulses 34 cycles apart with `out`=0xFFFF_FFFF and then 3. Asserting `rst` mid-second-operation → all outputs 0 and no second `finish`.
